// File: rtl/event_priority_encoder.sv
// event_priority_encoder
//   Captures rising edges on N_REQ asynchronous request pins into sticky pending
//   flags and presents the selected pending index as a registered binary code with
//   a valid flag, a pending-count popcount and a sticky overflow flag. A rising edge
//   on the asynchronous ack pin retires the code currently presented.
//   All inputs pass a 2-flop synchronizer plus a 1-flop delay used for edge detection.
//   Optional feature macro: PRIO_ROTATE_EN (round-robin selection with a last_grant
//   register). When the macro is undefined the lowest pending index always wins.
module event_priority_encoder #(
    parameter int N_REQ  = 5,
    parameter int CODE_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic [CODE_W-1:0] pend_cnt,
    output logic              overflow
);

    // Synchronizer and edge-detect stages.
    logic [N_REQ-1:0]  req_sync1;
    logic [N_REQ-1:0]  req_sync2;
    logic [N_REQ-1:0]  req_dly;
    logic              ack_sync1;
    logic              ack_sync2;
    logic              ack_dly;

    // Detected edges and derived control.
    logic [N_REQ-1:0]  req_edge;
    logic              ack_edge;
    logic              ack_accept;
    logic [N_REQ-1:0]  clr_mask;

    // Pending state and next-state values.
    logic [N_REQ-1:0]  pending;
    logic [N_REQ-1:0]  pending_next;
    logic              overflow_next;

    // Selection results taken from the pending register.
    logic [CODE_W-1:0] sel_code;
    logic              sel_found;
    logic [CODE_W-1:0] sel_cnt;

`ifdef PRIO_ROTATE_EN
    logic [CODE_W-1:0] last_grant;
    logic [CODE_W-1:0] rr_start;
`endif

    // Double-flop synchronize req/ack and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync1 <= '0;
            req_sync2 <= '0;
            req_dly   <= '0;
            ack_sync1 <= 1'b0;
            ack_sync2 <= 1'b0;
            ack_dly   <= 1'b0;
        end else begin
            req_sync1 <= req;
            req_sync2 <= req_sync1;
            req_dly   <= req_sync2;
            ack_sync1 <= ack;
            ack_sync2 <= ack_sync1;
            ack_dly   <= ack_sync2;
        end
    end

    // Rising-edge pulses; an ack only counts while a code is being presented.
    always_comb begin
        req_edge   = req_sync2 & ~req_dly;
        ack_edge   = ack_sync2 & ~ack_dly;
        ack_accept = ack_edge & valid;
    end

    // Clear mask for the presented code; a same-cycle set on that bit wins below.
    always_comb begin
        clr_mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ack_accept && (code == CODE_W'(i))) begin
                clr_mask[i] = 1'b1;
            end
        end
    end

    // Next pending vector and sticky overflow on an edge into an already-pending bit.
    always_comb begin
        pending_next  = req_edge | (pending & ~clr_mask);
        overflow_next = overflow | (|(req_edge & pending));
    end

    // Pending flags and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

`ifdef PRIO_ROTATE_EN
    // Remember the last retired code to rotate the search start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= '0;
        end else if (ack_accept) begin
            last_grant <= code;
        end
    end

    // Search starts one past the last grant, wrapping at N_REQ.
    always_comb begin
        if (int'(last_grant) >= N_REQ - 1) begin
            rr_start = '0;
        end else begin
            rr_start = last_grant + CODE_W'(1);
        end
    end

    // Round-robin pick: first pass covers [rr_start, N_REQ), second pass the
    // wrapped part; the second pass only runs when the first found nothing, so
    // any hit there is necessarily below rr_start.
    always_comb begin
        sel_code  = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!sel_found && pending[i] && (CODE_W'(i) >= rr_start)) begin
                sel_code  = CODE_W'(i);
                sel_found = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!sel_found && pending[i]) begin
                sel_code  = CODE_W'(i);
                sel_found = 1'b1;
            end
        end
    end
`else
    // Fixed priority pick: lowest pending index wins.
    always_comb begin
        sel_code  = '0;
        sel_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!sel_found && pending[i]) begin
                sel_code  = CODE_W'(i);
                sel_found = 1'b1;
            end
        end
    end
`endif

    // Popcount of the pending vector.
    always_comb begin
        sel_cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sel_cnt = sel_cnt + CODE_W'(pending[i]);
        end
    end

    // Register the outputs; code holds its last value when nothing is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code     <= '0;
            valid    <= 1'b0;
            pend_cnt <= '0;
        end else begin
            if (sel_found) begin
                code <= sel_code;
            end
            valid    <= sel_found;
            pend_cnt <= sel_cnt;
        end
    end

endmodule

// File: tb/tb_event_priority_encoder.sv
// Directed testbench for event_priority_encoder (default parameters).
// Expectations follow the PRIO_ROTATE_EN setting the bench is compiled with.
module tb_event_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic [4:0] req;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [2:0] pend_cnt;
    logic       overflow;

    int n_checks;
    int n_fail;

    event_priority_encoder #(
        .N_REQ  (5),
        .CODE_W (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ack      (ack),
        .code     (code),
        .valid    (valid),
        .pend_cnt (pend_cnt),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-clock pulse on req, then wait until the result is visible (edge k+3).
    task automatic pulse_req(input logic [4:0] mask);
        req = mask;
        step(1);
        req = '0;
        step(3);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(3);
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_code, input logic e_valid,
                             input logic [2:0] e_cnt, input logic e_ovf);
        check({tag, ".code"},     32'(code),     32'(e_code));
        check({tag, ".valid"},    32'(valid),    32'(e_valid));
        check({tag, ".pend_cnt"}, 32'(pend_cnt), 32'(e_cnt));
        check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        req      = '0;
        ack      = 1'b0;

        // Reset held: request/ack activity must be ignored.
        step(1);
        for (int i = 0; i < 4; i++) begin
            req = 5'b11111;
            ack = 1'b1;
            step(1);
            req = '0;
            ack = 1'b0;
            step(1);
        end
        check_out("rst", 3'd0, 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle.valid", 32'(valid), 32'd0);
        end
        check_out("idle", 3'd0, 1'b0, 3'd0, 1'b0);

        // Single event on req[3]: not yet visible at edge k+2, visible at k+3.
        req = 5'b01000;
        step(1);
        req = '0;
        step(2);
        check("lat.valid_early", 32'(valid), 32'd0);
        step(1);
        check_out("single", 3'd3, 1'b1, 3'd1, 1'b0);
        pulse_ack();
        check_out("single_ack", 3'd3, 1'b0, 3'd0, 1'b0);

        // Ack with nothing pending: no change.
        pulse_ack();
        check_out("idle_ack", 3'd3, 1'b0, 3'd0, 1'b0);

        // Level held high yields exactly one edge, no overflow.
        req = 5'b00001;
        step(10);
        req = '0;
        step(3);
        check_out("held", 3'd0, 1'b1, 3'd1, 1'b0);
        pulse_ack();
        check_out("held_ack", 3'd0, 1'b0, 3'd0, 1'b0);

`ifdef PRIO_ROTATE_EN
        // last_grant=0 -> search from 1.
        pulse_req(5'b10101);
        check_out("rr0", 3'd2, 1'b1, 3'd3, 1'b0);
        pulse_ack();
        check_out("rr1", 3'd4, 1'b1, 3'd2, 1'b0);
        // Re-raise bit 2: pending {0,2,4}, last_grant=2.
        pulse_req(5'b00100);
        check_out("rr2", 3'd4, 1'b1, 3'd3, 1'b0);
        pulse_ack();
        check_out("rr3_wrap", 3'd0, 1'b1, 3'd2, 1'b0);
        pulse_ack();
        check_out("rr4", 3'd2, 1'b1, 3'd1, 1'b0);
        pulse_ack();
        check_out("rr5", 3'd2, 1'b0, 3'd0, 1'b0);
`else
        pulse_req(5'b10110);
        check_out("prio0", 3'd1, 1'b1, 3'd3, 1'b0);
        pulse_ack();
        check_out("prio1", 3'd2, 1'b1, 3'd2, 1'b0);
        pulse_ack();
        check_out("prio2", 3'd4, 1'b1, 3'd1, 1'b0);
        pulse_ack();
        check_out("prio3", 3'd4, 1'b0, 3'd0, 1'b0);
`endif

        // Collision: req[2] edge lands with the ack retiring code 2.
        pulse_req(5'b00100);
        check_out("coll_pre", 3'd2, 1'b1, 3'd1, 1'b0);
        req = 5'b00100;
        ack = 1'b1;
        step(1);
        req = '0;
        ack = 1'b0;
        step(3);
        check_out("coll", 3'd2, 1'b1, 3'd1, 1'b1);
        pulse_ack();
        check_out("coll_ack", 3'd2, 1'b0, 3'd0, 1'b1);

        // Asynchronous reset between clock edges with three bits pending.
        pulse_req(5'b01011);
        check("arst_pre.pend_cnt", 32'(pend_cnt), 32'd3);
        check("arst_pre.valid", 32'(valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst", 3'd0, 1'b0, 3'd0, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(10);
        check_out("arst_after", 3'd0, 1'b0, 3'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
